// File: rtl/interval_arb_pkg.sv
// Shared types for the interval timer arbiter: default widths and FSM state encoding.
// Code 2'd3 is intentionally left unnamed; the FSM treats it as a recovery path to IDLE.
package interval_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/interval_counter.sv
// Up counter for timed intervals: count register updates on the edge after clr/en; no backpressure.
// clr (load zero) wins over en; the counter has no terminal logic of its own.
module interval_counter
    import interval_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin owner of one interval counter; grant 1 cycle after req in IDLE, interval runs req_len+1 cycles then a done pulse.
// Requests are sampled only at arbitration; define INTERVAL_PAUSE_EN to add a pause input that stalls RUN.
module interval_timer_arbiter
    import interval_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [CNT_W-1:0]           count,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id
`ifdef INTERVAL_PAUSE_EN
    ,
    input  logic                       pause
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr, owner_q, sel, cand;
    logic             found;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_arr [NUM_REQ];
    logic             run_en, cnt_clr, cnt_en, arb_win, iv_end, grant_clr;

`ifdef INTERVAL_PAUSE_EN
    assign run_en = ~pause;
`else
    assign run_en = 1'b1;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = req_len[g*CNT_W +: CNT_W];
    end

    // Scan starts one past the last owner so a held request cannot starve the others.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        arb_win   = 1'b0;
        iv_end    = 1'b0;
        grant_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    arb_win = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Count stops at len_q, so a terminal count of all-ones never wraps.
                if (run_en) begin
                    if (count == len_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DONE: begin
                iv_end    = 1'b1;
                grant_clr = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                grant_clr = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant   <= '0;
            owner_q <= '0;
            len_q   <= '0;
            rr_ptr  <= IDW'(NUM_REQ - 1);
        end else begin
            if (arb_win) begin
                grant   <= NUM_REQ'(1) << sel;
                owner_q <= sel;
                len_q   <= len_arr[sel];
            end else if (grant_clr) begin
                grant <= '0;
            end
            if (iv_end) begin
                rr_ptr <= owner_q;
            end
        end
    end

    interval_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign busy    = (state_q == RUN) || (state_q == DONE);
    assign done    = (state_q == DONE);
    assign done_id = owner_q;

endmodule
